// File: rtl/systolic_feeder_pkg.sv
// Shared constants for the systolic interpolator feeder: widths, priming depth,
// donext spacing limits and FSM state encodings.
package systolic_feeder_pkg;

    localparam int WORDLENGTH_DEF = 16;
    localparam int GAP_DEF        = 18;
    localparam int GAP_MIN        = 5;
    localparam int FIFO_DEPTH_DEF = 4;
    // Interpolator order: captures discarded while the wrapper delay line primes.
    localparam int FILL           = 8;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_LOAD    = 3'd1;
    localparam state_t ST_ISSUE   = 3'd2;
    localparam state_t ST_CAPTURE = 3'd3;
    localparam state_t ST_WAIT    = 3'd4;

    function automatic int fill_width(input int fill_n);
        return $clog2(fill_n + 1);
    endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// Bundle of the feeder's sample input, wrapper-side and result output signals.
// master = feeder side, slave = environment (source, wrapper, sink).
interface systolic_feeder_if #(
    parameter int WORDLENGTH = 16
);
    logic [WORDLENGTH-1:0] in_word;
    logic                  in_valid;
    logic                  in_ready;
    logic [WORDLENGTH-1:0] inputword;
    logic                  donext;
    logic [WORDLENGTH-1:0] outputword;
    logic [WORDLENGTH-1:0] inputword_delayed;
    logic [WORDLENGTH-1:0] out_word;
    logic [WORDLENGTH-1:0] out_delayed;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        input  in_word, in_valid, outputword, inputword_delayed, out_ready,
        output in_ready, inputword, donext, out_word, out_delayed, out_valid
    );

    modport slave (
        output in_word, in_valid, outputword, inputword_delayed, out_ready,
        input  in_ready, inputword, donext, out_word, out_delayed, out_valid
    );
endinterface

// File: rtl/systolic_feeder_sample_fifo.sv
// Small synchronous sample FIFO with show-ahead head output; pointers carry
// an extra wrap bit so full and empty are distinguishable.
module systolic_feeder_sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end
endmodule

// File: rtl/systolic_feeder.sv
// Feeds buffered samples to the Chebyshev systolic interpolator one per donext
// strobe, spaced GAP clocks apart, and forwards its results once primed.
module systolic_feeder
    import systolic_feeder_pkg::*;
#(
    parameter int WORDLENGTH = WORDLENGTH_DEF,
    parameter int GAP        = GAP_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int FILL_N     = FILL
) (
    input  logic             clk30x,
    input  logic             reset_n,
    systolic_feeder_if.master bus
);
    localparam int         FW       = fill_width(FILL_N);
    localparam logic [7:0] GAP_LOAD = 8'(GAP - 4);

    state_t                state_q, state_d;
    logic [WORDLENGTH-1:0] inputword_q, inputword_d;
    logic                  donext_q, donext_d;
    logic [WORDLENGTH-1:0] out_word_q, out_word_d;
    logic [WORDLENGTH-1:0] out_delayed_q, out_delayed_d;
    logic                  out_valid_q, out_valid_d;
    logic [FW-1:0]         fill_q, fill_d;
    logic [7:0]            gap_q, gap_d;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [WORDLENGTH-1:0] fifo_head;
    logic                  out_free;

    assign fifo_push = bus.in_valid && !fifo_full;
    // Output slot is free if empty now or being drained this very cycle.
    assign out_free  = !out_valid_q || bus.out_ready;

    systolic_feeder_sample_fifo #(
        .WIDTH (WORDLENGTH),
        .DEPTH (FIFO_DEPTH)
    ) u_sample_fifo (
        .clk   (clk30x),
        .rst_n (reset_n),
        .push  (fifo_push),
        .wdata (bus.in_word),
        .pop   (fifo_pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d       = state_q;
        inputword_d   = inputword_q;
        donext_d      = 1'b0;
        out_word_d    = out_word_q;
        out_delayed_d = out_delayed_q;
        out_valid_d   = out_valid_q;
        fill_d        = fill_q;
        gap_d         = gap_q;
        fifo_pop      = 1'b0;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && out_free) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                inputword_d = fifo_head;
                fifo_pop    = 1'b1;
                donext_d    = 1'b1;
                state_d     = ST_ISSUE;
            end
            ST_ISSUE: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (fill_q < FW'(FILL_N)) begin
                    fill_d = fill_q + 1'b1;
                end else begin
                    out_word_d    = bus.outputword;
                    out_delayed_d = bus.inputword_delayed;
                    out_valid_d   = 1'b1;
                end
                gap_d   = GAP_LOAD;
                state_d = (GAP_LOAD == 8'd0) ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                gap_d = gap_q - 8'd1;
                if (gap_q <= 8'd1) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk30x or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            inputword_q   <= '0;
            donext_q      <= 1'b0;
            out_word_q    <= '0;
            out_delayed_q <= '0;
            out_valid_q   <= 1'b0;
            fill_q        <= '0;
            gap_q         <= '0;
        end else begin
            state_q       <= state_d;
            inputword_q   <= inputword_d;
            donext_q      <= donext_d;
            out_word_q    <= out_word_d;
            out_delayed_q <= out_delayed_d;
            out_valid_q   <= out_valid_d;
            fill_q        <= fill_d;
            gap_q         <= gap_d;
        end
    end

    assign bus.in_ready    = !fifo_full;
    assign bus.inputword   = inputword_q;
    assign bus.donext      = donext_q;
    assign bus.out_word    = out_word_q;
    assign bus.out_delayed = out_delayed_q;
    assign bus.out_valid   = out_valid_q;
endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder (GAP=18 and GAP=5) against a simple
// wrapper model: outputword = sample + 0x100, delayed tap = sample 7 strobes back.
module tb_systolic_feeder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   width_err = 0;
    logic prev_dn18 = 1'b0;
    int   last_push_cyc = 0;

    int          dn18 [$];
    int          dn5 [$];
    logic [15:0] ow_q [$];
    logic [15:0] od_q [$];
    logic [6:0][15:0] dl18;
    logic [6:0][15:0] dl5;

    systolic_feeder_if #(.WORDLENGTH(16)) b18 ();
    systolic_feeder_if #(.WORDLENGTH(16)) b5 ();

    systolic_feeder #(.WORDLENGTH(16), .GAP(18), .FIFO_DEPTH(4), .FILL_N(8)) dut18 (
        .clk30x (clk), .reset_n (rst_n), .bus (b18)
    );
    systolic_feeder #(.WORDLENGTH(16), .GAP(5), .FIFO_DEPTH(4), .FILL_N(8)) dut5 (
        .clk30x (clk), .reset_n (rst_n), .bus (b5)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Wrapper models, reset with the same event as the feeders.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl18 <= '0;
            b18.outputword <= '0;
            b18.inputword_delayed <= '0;
        end else if (b18.donext) begin
            dl18 <= {dl18[5:0], b18.inputword};
            b18.outputword <= b18.inputword + 16'h0100;
            b18.inputword_delayed <= dl18[6];
        end
    end
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl5 <= '0;
            b5.outputword <= '0;
            b5.inputword_delayed <= '0;
        end else if (b5.donext) begin
            dl5 <= {dl5[5:0], b5.inputword};
            b5.outputword <= b5.inputword + 16'h0100;
            b5.inputword_delayed <= dl5[6];
        end
    end

    always @(negedge clk) begin
        if (b18.donext) begin
            dn18.push_back(cyc);
            if (prev_dn18) width_err <= width_err + 1;
        end
        prev_dn18 <= b18.donext;
        if (b18.out_valid && b18.out_ready) begin
            ow_q.push_back(b18.out_word);
            od_q.push_back(b18.out_delayed);
        end
        if (b5.donext) dn5.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic push(input logic [15:0] x);
        bit ok = 1'b0;
        b18.in_word  = x;
        b18.in_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (b18.in_ready) begin
                last_push_cyc = cyc;
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
        end
        b18.in_valid = 1'b0;
        if (!ok) check("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_dn(input int n0, output int c);
        c = -1;
        for (int i = 0; i < 300; i++) begin
            if (dn18.size() > n0) begin
                c = dn18[n0];
                break;
            end
            @(negedge clk); #1;
        end
        if (c < 0) check("donext_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int c, c13, p, n0, n1, pc, acc;
        bit got;
        b18.in_word = '0; b18.in_valid = 1'b0; b18.out_ready = 1'b1;
        b5.in_word  = '0; b5.in_valid  = 1'b0; b5.out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(b18.in_ready), 32'd1);
        check("rst_donext", 32'(b18.donext), 32'd0);
        check("rst_out_valid", 32'(b18.out_valid), 32'd0);
        check("rst_inputword", 32'(b18.inputword), 32'd0);
        check("rst_out_word", 32'(b18.out_word), 32'd0);
        @(posedge clk); #1;

        // Fill then stream: samples 1..12.
        for (int k = 1; k <= 12; k++) push(16'(k));
        for (int i = 0; i < 400 && dn18.size() < 12; i++) @(posedge clk);
        check("fill_dn_count", 32'(dn18.size()), 32'd12);
        for (int i = 1; i < 12 && i < dn18.size(); i++)
            check($sformatf("gap18_%0d", i), 32'(dn18[i] - dn18[i-1]), 32'd18);
        repeat (25) @(posedge clk); #1;
        check("fill_out_count", 32'(ow_q.size()), 32'd4);

        // Input starvation.
        push(16'd13);
        wait_dn(dn18.size(), c13);
        repeat (40) @(posedge clk); #1;
        n0 = dn18.size();
        push(16'd14);
        p = last_push_cyc;
        wait_dn(n0, c);
        check("starve_latency", 32'(c - p), 32'd3);
        check("starve_spacing_gt18", 32'((c - c13) > 18), 32'd1);
        repeat (25) @(posedge clk); #1;

        // Output stall and FIFO full.
        b18.out_ready = 1'b0;
        push(16'd15);
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (b18.out_valid) begin got = 1'b1; break; end
        end
        check("stall_valid", 32'(got), 32'd1);
        check("stall_word", 32'(b18.out_word), 32'h010F);
        check("stall_delayed", 32'(b18.out_delayed), 32'd8);
        @(posedge clk); #1;
        for (int k = 16; k <= 19; k++) push(16'(k));
        @(negedge clk);
        check("full_in_ready", 32'(b18.in_ready), 32'd0);
        @(posedge clk); #1;
        n0 = dn18.size();
        acc = 0;
        b18.in_word = 16'd20; b18.in_valid = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (b18.in_ready) acc++;
        end
        @(posedge clk); #1;
        b18.in_valid = 1'b0;
        check("full_no_accept", 32'(acc), 32'd0);
        check("stall_word_held", 32'(b18.out_word), 32'h010F);
        check("stall_no_donext", 32'(dn18.size()), 32'(n0));
        b18.out_ready = 1'b1;
        @(negedge clk); #1;
        pc = cyc;
        @(posedge clk); #1;
        b18.out_ready = 1'b0;
        @(negedge clk);
        check("pulse_clears_valid", 32'(b18.out_valid), 32'd0);
        wait_dn(n0, c);
        check("pulse_load_latency", 32'(c - pc), 32'd2);
        @(posedge clk); #1;
        b18.out_ready = 1'b1;
        push(16'd20);
        push(16'd21);
        repeat (150) @(posedge clk); #1;

        // Reset mid-WAIT with three samples still buffered.
        b18.out_ready = 1'b0;
        n0 = dn18.size();
        for (int k = 22; k <= 25; k++) push(16'(k));
        wait_dn(n0, c);
        repeat (5) @(posedge clk); #1;
        check("prereset_valid", 32'(b18.out_valid), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check("arst_donext", 32'(b18.donext), 32'd0);
        check("arst_out_valid", 32'(b18.out_valid), 32'd0);
        check("arst_in_ready", 32'(b18.in_ready), 32'd1);
        check("arst_inputword", 32'(b18.inputword), 32'd0);
        check("arst_out_word", 32'(b18.out_word), 32'd0);
        check("arst_out_delayed", 32'(b18.out_delayed), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        n1 = dn18.size();
        repeat (60) @(posedge clk); #1;
        check("postrst_no_donext", 32'(dn18.size()), 32'(n1));
        b18.out_ready = 1'b1;
        push(16'd26);
        p = last_push_cyc;
        wait_dn(n1, c);
        check("postrst_latency", 32'(c - p), 32'd3);
        repeat (20) @(posedge clk); #1;
        check("postrst_inputword", 32'(b18.inputword), 32'd26);
        check("postrst_refill_discard", 32'(ow_q.size()), 32'd13);

        // Scoreboard: accepted results are samples 9..21 in order.
        for (int i = 0; i < 13 && i < ow_q.size(); i++) begin
            check($sformatf("sb_word_%0d", i), 32'(ow_q[i]), 32'h0100 + 32'(9 + i));
            check($sformatf("sb_delayed_%0d", i), 32'(od_q[i]), 32'(2 + i));
        end
        check("donext_width", 32'(width_err), 32'd0);

        // Minimum gap instance.
        b5.in_word = 16'd1; b5.in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            got = b5.in_ready;
            @(posedge clk); #1;
            if (got) begin
                if (b5.in_word == 16'd12) break;
                b5.in_word = b5.in_word + 16'd1;
            end
        end
        b5.in_valid = 1'b0;
        for (int i = 0; i < 300 && dn5.size() < 12; i++) @(posedge clk);
        check("gap5_dn_count", 32'(dn5.size()), 32'd12);
        for (int i = 1; i < 12 && i < dn5.size(); i++)
            check($sformatf("gap5_%0d", i), 32'(dn5[i] - dn5[i-1]), 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
